// File: rtl/clk_gate_pkg.sv
// Shared types and limits for the clock-gating enable controller.
// State encoding, counter width and parameter range checking.
package clk_gate_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   localparam int CNT_W = 4;

   localparam int N_REQ_MIN = 1;
   localparam int N_REQ_MAX = 8;
   localparam int WAKE_MIN  = 1;
   localparam int WAKE_MAX  = 15;
   localparam int IDLE_MIN  = 0;
   localparam int IDLE_MAX  = 15;

   function automatic bit params_ok(
      input int n_req,
      input int wake_cyc,
      input int idle_cyc
   );
      bit ok;
      ok = 1'b1;
      if (n_req < N_REQ_MIN || n_req > N_REQ_MAX) begin
         ok = 1'b0;
      end
      if (wake_cyc < WAKE_MIN || wake_cyc > WAKE_MAX) begin
         ok = 1'b0;
      end
      if (idle_cyc < IDLE_MIN || idle_cyc > IDLE_MAX) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/clk_gate_timer.sv
// Loadable down-counter shared by the wake-up and idle-hysteresis phases.
// Decrement saturates at zero so the count can never wrap.
module clk_gate_timer
   import clk_gate_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable controller for a shared gated clock domain: wake settle delay
// before grant, idle hysteresis before gating off, DFT force-on.
module clk_gate_ctrl
   import clk_gate_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int WAKE_CYC = 2,
   parameter int IDLE_CYC = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_REQ-1:0] REQ,
   input  logic             FORCE_ON,
   input  logic             TEST_EN,
   output logic             CLK_EN,
   output logic [N_REQ-1:0] GNT,
   output logic             READY,
   output logic             IDLE
);

   if (!params_ok(N_REQ, WAKE_CYC, IDLE_CYC)) begin : g_bad_params
      $error("clk_gate_ctrl: parameter out of range");
   end

   localparam bit               HAS_IDLE = (IDLE_CYC > 0);
   localparam logic [CNT_W-1:0] WAKE_LD  = CNT_W'(WAKE_CYC - 1);
   localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(IDLE_CYC - 1);

   state_e           state_q;
   logic             en_q;
   logic             ready_q;
   logic             any;
   logic             t_load;
   logic [CNT_W-1:0] t_val;
   logic             t_dec;
   logic             t_zero;

   assign any = (|REQ) | FORCE_ON;

   always_comb begin
      t_load = 1'b0;
      t_val  = '0;
      t_dec  = 1'b0;
      unique case (state_q)
         ST_OFF: begin
            if (any) begin
               t_load = 1'b1;
               t_val  = WAKE_LD;
            end
         end
         ST_WAKE: begin
            t_dec = 1'b1;
         end
         ST_ON: begin
            if (!any && HAS_IDLE) begin
               t_load = 1'b1;
               t_val  = IDLE_LD;
            end
         end
         ST_HOLD: begin
            // A returning request freezes the count; ON reloads it later.
            t_dec = !any;
         end
         default: begin
            t_dec = 1'b0;
         end
      endcase
   end

   clk_gate_timer u_timer (
      .clk_i      (CLK),
      .rst_ni     (RST),
      .load_i     (t_load),
      .load_val_i (t_val),
      .dec_i      (t_dec),
      .zero_o     (t_zero)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= ST_OFF;
         en_q    <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_OFF: begin
               if (any) begin
                  state_q <= ST_WAKE;
                  en_q    <= 1'b1;
               end
            end
            ST_WAKE: begin
               if (t_zero) begin
                  state_q <= ST_ON;
                  ready_q <= 1'b1;
               end
            end
            ST_ON: begin
               if (!any) begin
                  if (HAS_IDLE) begin
                     state_q <= ST_HOLD;
                  end else begin
                     state_q <= ST_OFF;
                     en_q    <= 1'b0;
                     ready_q <= 1'b0;
                  end
               end
            end
            ST_HOLD: begin
               if (any) begin
                  state_q <= ST_ON;
               end else if (t_zero) begin
                  state_q <= ST_OFF;
                  en_q    <= 1'b0;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_OFF;
               en_q    <= 1'b0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign CLK_EN = en_q | TEST_EN;
   assign GNT    = REQ & {N_REQ{ready_q}};
   assign READY  = ready_q;
   assign IDLE   = (state_q == ST_OFF);

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed vector table, reset/idle hold,
// then randomized traffic against a timing-level reference model.
module tb_clk_gate_ctrl;

   localparam int N = 2;
   localparam int W = 2;
   localparam int I = 4;

   logic         CLK;
   logic         RST;
   logic [N-1:0] REQ;
   logic         FORCE_ON;
   logic         TEST_EN;
   logic         CLK_EN;
   logic [N-1:0] GNT;
   logic         READY;
   logic         IDLE;

   int errors = 0;
   int checks = 0;

   clk_gate_ctrl #(
      .N_REQ    (N),
      .WAKE_CYC (W),
      .IDLE_CYC (I)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .REQ      (REQ),
      .FORCE_ON (FORCE_ON),
      .TEST_EN  (TEST_EN),
      .CLK_EN   (CLK_EN),
      .GNT      (GNT),
      .READY    (READY),
      .IDLE     (IDLE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Model: clock enabled flag, ready flag, edges since enable, idle streak.
   bit m_en;
   bit m_ready;
   int m_since;
   int m_idle;

   task automatic model_edge();
      bit any;
      any = (|REQ) || FORCE_ON;
      if (!RST) begin
         m_en    = 0;
         m_ready = 0;
         m_since = 0;
         m_idle  = 0;
      end else if (!m_en) begin
         if (any) begin
            m_en    = 1;
            m_since = 0;
         end
      end else if (!m_ready) begin
         m_since++;
         if (m_since >= W) begin
            m_ready = 1;
            m_idle  = 0;
         end
      end else if (any) begin
         m_idle = 0;
      end else begin
         m_idle++;
         if (m_idle > I) begin
            m_en    = 0;
            m_ready = 0;
            m_idle  = 0;
         end
      end
   endtask

   task automatic cycle(
      input logic         rst,
      input logic [N-1:0] req,
      input logic         frc,
      input logic         tst
   );
      @(posedge CLK);
      model_edge();
      #2;
      RST      = rst;
      REQ      = req;
      FORCE_ON = frc;
      TEST_EN  = tst;
      #1;
   endtask

   task automatic check(
      input string        name,
      input logic         e_en,
      input logic         e_rdy,
      input logic [N-1:0] e_gnt,
      input logic         e_idle
   );
      checks += 4;
      if (CLK_EN !== e_en) begin
         errors++;
         $display("FAIL %s: CLK_EN=%b expected %b", name, CLK_EN, e_en);
      end
      if (READY !== e_rdy) begin
         errors++;
         $display("FAIL %s: READY=%b expected %b", name, READY, e_rdy);
      end
      if (GNT !== e_gnt) begin
         errors++;
         $display("FAIL %s: GNT=%b expected %b", name, GNT, e_gnt);
      end
      if (IDLE !== e_idle) begin
         errors++;
         $display("FAIL %s: IDLE=%b expected %b", name, IDLE, e_idle);
      end
   endtask

   typedef struct {
      logic         rst;
      logic [N-1:0] req;
      logic         frc;
      logic         tst;
      logic         en;
      logic         rdy;
      logic [N-1:0] gnt;
      logic         idle;
   } vec_t;

   localparam int NV = 55;
   vec_t tbl[NV];

   function automatic vec_t v(
      input logic rst, input logic [N-1:0] req,
      input logic frc, input logic tst,
      input logic en, input logic rdy,
      input logic [N-1:0] gnt, input logic idle
   );
      vec_t r;
      r.rst = rst; r.req = req; r.frc = frc; r.tst = tst;
      r.en = en; r.rdy = rdy; r.gnt = gnt; r.idle = idle;
      return r;
   endfunction

   initial begin
      // Row inputs are applied mid-cycle; expected outputs reflect state
      // after the previous rows' edges plus this row's combinational inputs.
      tbl[0]  = v(1, 2'b00, 0, 0, 0, 0, 2'b00, 1);
      tbl[1]  = v(1, 2'b01, 0, 0, 0, 0, 2'b00, 1);
      tbl[2]  = v(1, 2'b01, 0, 0, 1, 0, 2'b00, 0);
      tbl[3]  = v(1, 2'b01, 0, 0, 1, 0, 2'b00, 0);
      tbl[4]  = v(1, 2'b01, 0, 0, 1, 1, 2'b01, 0);
      tbl[5]  = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[6]  = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[7]  = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[8]  = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[9]  = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[10] = v(1, 2'b00, 0, 0, 0, 0, 2'b00, 1);
      tbl[11] = v(1, 2'b10, 0, 0, 0, 0, 2'b00, 1);
      tbl[12] = v(1, 2'b10, 0, 0, 1, 0, 2'b00, 0);
      tbl[13] = v(1, 2'b10, 0, 0, 1, 0, 2'b00, 0);
      tbl[14] = v(1, 2'b10, 0, 0, 1, 1, 2'b10, 0);
      tbl[15] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[16] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[17] = v(1, 2'b10, 0, 0, 1, 1, 2'b10, 0);
      tbl[18] = v(1, 2'b10, 0, 0, 1, 1, 2'b10, 0);
      tbl[19] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[20] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[21] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[22] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[23] = v(1, 2'b11, 0, 0, 1, 1, 2'b11, 0);
      tbl[24] = v(1, 2'b11, 0, 0, 1, 1, 2'b11, 0);
      tbl[25] = v(1, 2'b00, 1, 0, 1, 1, 2'b00, 0);
      tbl[26] = v(1, 2'b00, 1, 0, 1, 1, 2'b00, 0);
      tbl[27] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[28] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[29] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[30] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[31] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[32] = v(1, 2'b00, 0, 0, 0, 0, 2'b00, 1);
      tbl[33] = v(1, 2'b00, 1, 0, 0, 0, 2'b00, 1);
      tbl[34] = v(1, 2'b00, 1, 0, 1, 0, 2'b00, 0);
      tbl[35] = v(1, 2'b00, 0, 0, 1, 0, 2'b00, 0);
      tbl[36] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[37] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[38] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[39] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[40] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);
      tbl[41] = v(1, 2'b00, 0, 0, 0, 0, 2'b00, 1);
      tbl[42] = v(1, 2'b00, 0, 1, 1, 0, 2'b00, 1);
      tbl[43] = v(1, 2'b00, 0, 1, 1, 0, 2'b00, 1);
      tbl[44] = v(1, 2'b00, 0, 0, 0, 0, 2'b00, 1);
      tbl[45] = v(1, 2'b11, 0, 0, 0, 0, 2'b00, 1);
      tbl[46] = v(1, 2'b11, 0, 0, 1, 0, 2'b00, 0);
      tbl[47] = v(1, 2'b11, 0, 0, 1, 0, 2'b00, 0);
      tbl[48] = v(1, 2'b11, 0, 0, 1, 1, 2'b11, 0);
      tbl[49] = v(0, 2'b11, 0, 0, 1, 1, 2'b11, 0);
      tbl[50] = v(1, 2'b11, 0, 0, 0, 0, 2'b00, 1);
      tbl[51] = v(1, 2'b11, 0, 0, 1, 0, 2'b00, 0);
      tbl[52] = v(1, 2'b11, 0, 0, 1, 0, 2'b00, 0);
      tbl[53] = v(1, 2'b11, 0, 0, 1, 1, 2'b11, 0);
      tbl[54] = v(1, 2'b00, 0, 0, 1, 1, 2'b00, 0);

      RST      = 1'b0;
      REQ      = '0;
      FORCE_ON = 1'b0;
      TEST_EN  = 1'b0;

      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 2'b00, 1'b0, 1'b0);
      end

      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 2'b00, 1'b0, 1'b0);
         check($sformatf("idle%0d", k), 1'b0, 1'b0, 2'b00, 1'b1);
      end

      for (int k = 0; k < NV; k++) begin
         cycle(tbl[k].rst, tbl[k].req, tbl[k].frc, tbl[k].tst);
         check($sformatf("vec%0d", k),
               tbl[k].en, tbl[k].rdy, tbl[k].gnt, tbl[k].idle);
      end

      for (int k = 0; k < 3000; k++) begin
         logic [N-1:0] r;
         logic         rs;
         logic         f;
         logic         t;
         rs = ($urandom_range(0, 99) != 0);
         r  = ($urandom_range(0, 3) == 0) ? N'($urandom) : REQ;
         if ($urandom_range(0, 5) == 0) begin
            r = '0;
         end
         f = ($urandom_range(0, 39) == 0) ? ~FORCE_ON : FORCE_ON;
         t = ($urandom_range(0, 29) == 0);
         cycle(rs, r, f, t);
         check($sformatf("rand%0d", k),
               m_en | TEST_EN,
               m_ready,
               REQ & {N{m_ready}},
               !m_en);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
